mul21_result_serializer: RTL and testbench

Downstream stage of the 21×21 cascade compressor harness. It captures the 42 single-bit product columns (`dst0`…`dst41`) on a sample strobe and streams them out as six 8-bit bytes, LSB first, over a valid/ready handshake. It has a one-deep pending buffer so that back-to-back products are emitted without bubbles, and a sticky overrun flag for dropped samples.

---
 rtl/mul21_result_serializer.sv | 163 ++++++++++++++++
 tb/tb_mul21_result_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul21_result_serializer.sv
// mul21_result_serializer
//
// Captures the 42 product columns of the mul21 compressor on a sample strobe and streams them out
// LSB first as six 8-bit bytes over a valid/ready handshake. A one-deep pending buffer lets
// back-to-back products go out without bubbles. A sticky flag records any dropped samples.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   dst0..dst41    product bits, dst0 is the LSB
//   sample_en      capture strobe for the current dst* value
//   out_data       current byte (zero when out_valid is low)
//   out_valid      out_data is valid
//   out_ready      consumer accepts the byte
//   out_last       high with the final byte (index 5) of each product
//   busy           high while a frame is being sent
//   overrun        sticky, a sample was dropped
//   overrun_clr    synchronous clear of overrun (a same-cycle drop wins)
module mul21_result_serializer #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned BYTES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,
  input  logic       dst8,  dst9,  dst10, dst11, dst12, dst13, dst14, dst15,
  input  logic       dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23,
  input  logic       dst24, dst25, dst26, dst27, dst28, dst29, dst30, dst31,
  input  logic       dst32, dst33, dst34, dst35, dst36, dst37, dst38, dst39,
  input  logic       dst40, dst41,
  input  logic       sample_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam int unsigned FW = BYTES * 8;
  localparam logic [2:0] LastIdx = 3'(BYTES - 1);

  typedef enum logic {StIdle, StSend} state_e;

  logic [WIDTH-1:0] dst_vec;
  logic [FW-1:0]    frame;

  assign dst_vec = {dst41, dst40, dst39, dst38, dst37, dst36, dst35, dst34, dst33, dst32,
                    dst31, dst30, dst29, dst28, dst27, dst26, dst25, dst24, dst23, dst22,
                    dst21, dst20, dst19, dst18, dst17, dst16, dst15, dst14, dst13, dst12,
                    dst11, dst10, dst9,  dst8,  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,
                    dst1,  dst0};
  assign frame = {{(FW - WIDTH){1'b0}}, dst_vec};

  state_e        state_q, state_d;
  logic [FW-1:0] cur_q, cur_d;
  logic [FW-1:0] pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [2:0]    idx_q, idx_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_last_q;

  logic hs;
  logic last_hs;
  logic drop;

  // In SEND out_valid is always high, so the handshake reduces to out_ready.
  assign hs      = (state_q == StSend) && out_ready;
  assign last_hs = hs && (idx_q == LastIdx);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    idx_d    = idx_q;
    drop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sample_en) begin
          cur_d   = frame;
          idx_d   = 3'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (last_hs) begin
          if (pend_v_q) begin
            cur_d = pend_q;
            idx_d = 3'd0;
            // A coincident strobe refills the slot just vacated.
            if (sample_en) begin
              pend_d = frame;
            end else begin
              pend_v_d = 1'b0;
            end
          end else if (sample_en) begin
            cur_d = frame;
            idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + 3'd1;
          end
          if (sample_en) begin
            if (!pend_v_q) begin
              pend_d   = frame;
              pend_v_d = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);

    // Outputs are registered from next-state values so they line up with the new state.
    out_data_d = 8'h00;
    if (state_d == StSend) begin
      for (int k = 0; k < BYTES; k++) begin
        if (idx_d == 3'(k)) out_data_d = cur_d[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      idx_q       <= 3'd0;
      overrun_q   <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
      out_data_q  <= out_data_d;
      out_valid_q <= (state_d == StSend);
      out_last_q  <= (state_d == StSend) && (idx_d == LastIdx);
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mul21_result_serializer.sv
module tb_mul21_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [41:0] dst = '0;
  logic        sample_en = 1'b0;
  logic        out_ready = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul21_result_serializer dut (
    .clk(clk), .rst_n(rst_n),
    .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),
    .dst4(dst[4]),   .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),
    .dst8(dst[8]),   .dst9(dst[9]),   .dst10(dst[10]), .dst11(dst[11]),
    .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]), .dst15(dst[15]),
    .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
    .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]),
    .dst24(dst[24]), .dst25(dst[25]), .dst26(dst[26]), .dst27(dst[27]),
    .dst28(dst[28]), .dst29(dst[29]), .dst30(dst[30]), .dst31(dst[31]),
    .dst32(dst[32]), .dst33(dst[33]), .dst34(dst[34]), .dst35(dst[35]),
    .dst36(dst[36]), .dst37(dst[37]), .dst38(dst[38]), .dst39(dst[39]),
    .dst40(dst[40]), .dst41(dst[41]),
    .sample_en(sample_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] d, input logic l);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"}, 32'(out_data), 32'(d));
    chk({tag, " last"}, 32'(out_last), 32'(l));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(out_valid), 32'd0);
    chk({tag, " data"}, 32'(out_data), 32'd0);
    chk({tag, " last"}, 32'(out_last), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Checks six bytes with out_ready held high; ticks once after each byte.
  task automatic chk_frame(input string tag, input logic [7:0] b[6]);
    for (int k = 0; k < 6; k++) begin
      chk_byte($sformatf("%s b%0d", tag, k), b[k], k == 5);
      tick();
    end
  endtask

  task automatic strobe(input logic [41:0] v);
    dst = v;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    dst = 42'h155_AAAA_5555; // junk, must be ignored
  endtask

  initial begin
    logic [7:0] fa[6];
    logic [7:0] fb[6];

    // Reset state
    #12;
    chk_idle("reset");
    chk("reset overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_idle("post-reset");

    // Single all-ones product at full ready
    out_ready = 1'b1;
    strobe(42'h3FF_FFFF_FFFF);
    chk("t1 busy", 32'(busy), 32'd1);
    fa = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};
    chk_frame("t1", fa);
    chk_idle("t1 end");

    // Alternating product with stalls: each byte held two cycles before acceptance
    out_ready = 1'b0;
    strobe(42'h155_5555_5555);
    fa = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h01};
    for (int k = 0; k < 6; k++) begin
      out_ready = 1'b0;
      chk_byte($sformatf("t2 b%0d", k), fa[k], k == 5);
      tick();
      chk_byte($sformatf("t2 b%0d stall1", k), fa[k], k == 5);
      tick();
      chk_byte($sformatf("t2 b%0d stall2", k), fa[k], k == 5);
      out_ready = 1'b1;
      tick();
    end
    chk_idle("t2 end");

    // Two strobes 3 cycles apart: 12 contiguous bytes
    strobe(42'h000_0000_0001);
    fa = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    for (int k = 0; k < 12; k++) begin
      chk_byte($sformatf("t3 b%0d", k), (k < 6) ? fa[k] : fb[k-6], (k == 5) || (k == 11));
      if (k == 2) begin
        dst = 42'h200_0000_0000;
        sample_en = 1'b1;
      end
      tick();
      sample_en = 1'b0;
    end
    chk_idle("t3 end");
    chk("t3 overrun", 32'(overrun), 32'd0);

    // Three strobes in one stalled frame: third dropped
    out_ready = 1'b0;
    strobe(42'h012_3456_789A << 4 | 42'hB);
    strobe(42'h2FE_DCBA_9876);
    chk("t4 no overrun yet", 32'(overrun), 32'd0);
    strobe(42'h3C3_C3C3_C3C3);
    chk("t4 overrun set", 32'(overrun), 32'd1);
    chk_byte("t4 held", 8'hAB, 1'b0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t4 overrun clr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    fa = '{8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    fb = '{8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE, 8'h02};
    chk_frame("t4 f1", fa);
    chk_frame("t4 f2", fb);
    chk_idle("t4 end");

    // Strobe coincident with last-byte handshake, pending empty
    strobe(42'h000_0000_00A5);
    fa = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fb = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 12; k++) begin
      chk_byte($sformatf("t5 b%0d", k), (k < 6) ? fa[k] : fb[k-6], (k == 5) || (k == 11));
      if (k == 5) begin
        dst = 42'h000_0000_003C;
        sample_en = 1'b1;
      end
      tick();
      sample_en = 1'b0;
    end
    chk_idle("t5 end");

    // Asynchronous reset mid-frame at byte 3
    strobe(42'h3FF_FFFF_FFFF);
    tick();
    tick();
    tick();
    chk_byte("t6 b3", 8'hFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t6 async");
    chk("t6 overrun", 32'(overrun), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("t6 released");
    strobe(42'h0C0_FFEE_DDCC);
    fa = '{8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hC0, 8'h00};
    chk_frame("t6", fa);
    chk_idle("t6 end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
